fft_peak_reader: RTL and testbench
==================================

# fft_peak_reader

Result-side reader for the tuner FFT. When the FFT core signals `done`, this block sweeps the core's read address across the positive-frequency bins and computes the squared magnitude of each complex word. It tracks the strongest bin and reports its index and magnitude to the pitch-estimation logic. It is the consumer of the FFT core's `rd_adr` / `write_data` read port.

## Interface
- `bit_width`, 16, width of each real/imag component
- `N`, 512, FFT length (power of two)
- `M`, log2(N), address width
- `min_bin`, 1, first bin scanned (bins below are excluded; default skips DC)

- `clk` in 1, system clock
- `reset` in 1, asynchronous, active-low reset
- `fft_done` in 1, FFT core completion; sampled high in IDLE starts a scan
- `rd_adr` out M, bin address driven to FFT core read port
- `rd_data` in 2*bit_width, FFT word for `rd_adr` from previous cycle; [2*bit_width-1:bit_width] = signed real, [bit_width-1:0] = signed imag
- `busy` out 1, scan in progress
- `peak_valid` out 1, one-cycle pulse: new result available
- `peak_bin` out M, index of strongest bin (held between scans)
- `peak_mag` out 2*bit_width+1, re²+im² of strongest bin, unsigned (held between scans)

## Operation
- States:
  - IDLE: `rd_adr`=0, `busy`=0; waiting for `fft_done`.
  - SCAN: one address issued per cycle, `min_bin` .. N/2-1.
  - DRAIN: 2 cycles; pipeline empties.
  - REPORT: 1 cycle, `peak_valid`=1.
- Transitions:
  - IDLE→SCAN when `fft_done`=1.
  - SCAN→DRAIN after address N/2-1 is issued.
  - DRAIN→REPORT after 2 cycles.
  - REPORT→IDLE unconditionally.
- Pipeline:
  - Stage A: address issued; synchronous RAM returns `rd_data` next cycle.
  - Stage B: register re², im² (each signed×signed, 2*bit_width bits) and the bin index.
  - Stage C: sum into 2*bit_width+1 bits unsigned, compare to running peak, update.
- Running peak is cleared at SCAN entry to mag=0, bin=`min_bin`.
- Update occurs only on strictly greater magnitude, so ties keep the lowest bin.
- Result registers `peak_bin` / `peak_mag` load from the running peak on entry to REPORT only. Their values are unchanged during a scan.
- Arithmetic:
  - (-2^(bit_width-1))² = 2^(2*bit_width-2), which must be exact (no saturation).
  - Sum maximum is 2^(2*bit_width-1), so no overflow is possible.
- `fft_done` in any state other than IDLE is ignored. It is not queued.
- Reset is asserted low asynchronously in any state. All registers clear immediately and state returns to IDLE. A partial scan produces no `peak_valid`.

## Timing
- Reset values:
  - `rd_adr`=0, `busy`=0, `peak_valid`=0, `peak_bin`=0, `peak_mag`=0.
  - State IDLE, running peak cleared.
- Let L = N/2 − `min_bin` (255 at defaults).
- Cycle 0: `fft_done` sampled high in IDLE.
- Cycles 1..L:
  - `rd_adr` = `min_bin` + (cycle−1).
  - `busy`=1 from cycle 1.
- Bin issued in cycle c is squared at the edge ending c+1 and compared at the edge ending c+2.
- Cycles L+1, L+2: DRAIN, `busy`=1, `rd_adr`=0.
- Cycle L+3:
  - `peak_valid`=1 with final `peak_bin` / `peak_mag`.
  - `busy`=0.
- Cycle L+4: IDLE. The earliest new scan start is `fft_done` sampled in cycle L+4.
- Total latency is `fft_done` to `peak_valid` = L+3 cycles (258 at defaults).
- `min_bin` = N/2−1 gives L=1. This is legal and gives a 4-cycle latency.

## Test plan
- Single tone: bin 37 = (re 1000, im −500), all other bins = (3, 4). Expect `peak_valid` at cycle 258 with `peak_bin`=37, `peak_mag`=1,250,000. `rd_adr` must step 1..255 on consecutive cycles.
- All-zero spectrum. Expect `peak_bin`=1, `peak_mag`=0, `peak_valid` pulsed exactly once.
- Excluded DC and tie:
  - Bin 0 = (32767, 0) must be ignored.
  - Bins 20 and 100 = (0, 300), all others = 0.
  - Expect `peak_bin`=20, `peak_mag`=90,000.
- Extreme values: bin 255 = (−32768, −32768), others = (32767, 0). Expect `peak_bin`=255, `peak_mag`=2,147,483,648.
- Ignored start and held result:
  - After a completed scan with a tone at bin 37, pulse `fft_done` at cycle 100 of a second scan with the tone at bin 60.
  - Expect only one `peak_valid` (bin 60) at cycle 258 of the second scan.
  - `peak_bin` reads 37 until then.
- Reset mid-scan:
  - Assert `reset` low at cycle 50 of a scan.
  - All outputs go to 0 immediately, with no `peak_valid`.
  - After release, a fresh `fft_done` produces a correct result 258 cycles later.

Source files
------------

// File: rtl/fft_peak_reader_if.sv
// Read-port and result bundle between the FFT result reader and its neighbours.
// master = the reader (drives the RAM address and the peak report),
// slave  = the FFT core / pitch logic side.
interface fft_peak_if #(
    parameter int bit_width = 16,
    parameter int M         = 9
);
    logic                   fft_done;
    logic [M-1:0]           rd_adr;
    logic [2*bit_width-1:0] rd_data;
    logic                   busy;
    logic                   peak_valid;
    logic [M-1:0]           peak_bin;
    logic [2*bit_width:0]   peak_mag;

    modport master (
        input  fft_done, rd_data,
        output rd_adr, busy, peak_valid, peak_bin, peak_mag
    );

    modport slave (
        output fft_done, rd_data,
        input  rd_adr, busy, peak_valid, peak_bin, peak_mag
    );
endinterface

// File: rtl/fft_peak_reader.sv
// FFT peak reader: on fft_done, sweep bins min_bin..N/2-1 through the core's
// synchronous read port, square each complex word and keep the strongest bin.
// Pipeline: A = address issued, B = squares registered, C = sum + compare.
module fft_peak_reader #(
    parameter int bit_width = 16,
    parameter int N         = 512,
    parameter int M         = $clog2(N),
    parameter int min_bin   = 1
) (
    input  logic       clk,
    input  logic       reset,
    fft_peak_if.master bus
);
    localparam int          MW        = 2*bit_width + 1;
    localparam logic [M-1:0] FIRST_BIN = M'(min_bin);
    localparam logic [M-1:0] LAST_BIN  = M'(N/2 - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

    state_t               state_q;
    logic [M-1:0]         rd_adr_q;
    logic                 busy_q;
    logic                 peak_valid_q;
    logic [M-1:0]         peak_bin_q;
    logic [MW-1:0]        peak_mag_q;
    logic                 drain_q;

    // pipeline registers
    logic                 vld_a_q, vld_b_q;
    logic [M-1:0]         bin_a_q, bin_b_q;
    logic [2*bit_width-1:0] re_sq_q, im_sq_q;

    // running peak
    logic [MW-1:0]        run_mag_q, run_mag_d;
    logic [M-1:0]         run_bin_q, run_bin_d;

    // stage B squares: signed*signed in 2*bit_width, so (-2^(w-1))^2 stays exact
    logic signed [bit_width-1:0]   re_s, im_s;
    logic signed [2*bit_width-1:0] re_sq, im_sq;
    logic [MW-1:0]                 sum_c;
    logic                          upd_c;

    assign re_s  = bus.rd_data[2*bit_width-1:bit_width];
    assign im_s  = bus.rd_data[bit_width-1:0];
    assign re_sq = re_s * re_s;
    assign im_sq = im_s * im_s;

    // stage C: widen by one bit before adding so the sum can never wrap
    assign sum_c = {1'b0, re_sq_q} + {1'b0, im_sq_q};
    assign upd_c = vld_b_q && (sum_c > run_mag_q);

    // next running peak; strict compare keeps the lowest bin on ties
    always_comb begin
        run_mag_d = run_mag_q;
        run_bin_d = run_bin_q;
        if (upd_c) begin
            run_mag_d = sum_c;
            run_bin_d = bin_b_q;
        end
    end

    // control FSM with registered outputs; the result loads from run_*_d so the
    // last bin's compare (same edge) is included
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rd_adr_q     <= '0;
            busy_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            drain_q      <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.fft_done) begin
                        state_q  <= SCAN;
                        rd_adr_q <= FIRST_BIN;
                        busy_q   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (rd_adr_q == LAST_BIN) begin
                        state_q  <= DRAIN;
                        rd_adr_q <= '0;
                        drain_q  <= 1'b0;
                    end else begin
                        rd_adr_q <= rd_adr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state_q      <= REPORT;
                        busy_q       <= 1'b0;
                        peak_valid_q <= 1'b1;
                        peak_bin_q   <= run_bin_d;
                        peak_mag_q   <= run_mag_d;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                REPORT: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // datapath: track which cycles carry a real bin, square, and keep the peak
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_a_q   <= 1'b0;
            vld_b_q   <= 1'b0;
            bin_a_q   <= '0;
            bin_b_q   <= '0;
            re_sq_q   <= '0;
            im_sq_q   <= '0;
            run_mag_q <= '0;
            run_bin_q <= FIRST_BIN;
        end else begin
            vld_a_q <= (state_q == SCAN);
            bin_a_q <= rd_adr_q;
            vld_b_q <= vld_a_q;
            bin_b_q <= bin_a_q;
            re_sq_q <= re_sq;
            im_sq_q <= im_sq;
            if (state_q == IDLE && bus.fft_done) begin
                run_mag_q <= '0;
                run_bin_q <= FIRST_BIN;
            end else begin
                run_mag_q <= run_mag_d;
                run_bin_q <= run_bin_d;
            end
        end
    end

    assign bus.rd_adr     = rd_adr_q;
    assign bus.busy       = busy_q;
    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_mag   = peak_mag_q;
endmodule

// File: tb/tb_fft_peak_reader.sv
// Directed bench for fft_peak_reader at default parameters (N=512, min_bin=1).
module tb_fft_peak_reader;
    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    fft_peak_if #(.bit_width(16), .M(9)) bus ();

    fft_peak_reader #(.bit_width(16), .N(512), .M(9), .min_bin(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM model of the FFT core read port
    logic [31:0] mem [0:511];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_adr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int re, input int im);
        logic [15:0] r, i;
        r = 16'(re);
        i = 16'(im);
        return {r, i};
    endfunction

    task automatic fill(input int re, input int im);
        for (int i = 0; i < 512; i++) mem[i] = word(re, im);
    endtask

    // Start a scan and follow it for 262 cycles, checking the address sweep,
    // busy, the single peak_valid pulse at cycle 258, and the held result.
    task automatic run_scan(input string tag, input int exp_bin, input logic [63:0] exp_mag,
                            input int prev_bin, input int pulse_at);
        int          pv_cnt, pv_cyc;
        bit          adr_ok, busy_ok, held_ok;
        logic [63:0] got_bin, got_mag;
        logic [8:0]  exp_adr;
        pv_cnt = 0; pv_cyc = -1; adr_ok = 1; busy_ok = 1; held_ok = 1;
        got_bin = '0; got_mag = '0;
        bus.fft_done = 1'b1;
        step();
        bus.fft_done = 1'b0;
        for (int c = 1; c <= 262; c++) begin
            bus.fft_done = (c == pulse_at);
            exp_adr = (c <= 255) ? 9'(c) : 9'd0;
            if (bus.rd_adr !== exp_adr) adr_ok = 0;
            if (bus.busy !== (c <= 257)) busy_ok = 0;
            if (bus.peak_valid === 1'b1) begin
                pv_cnt++;
                pv_cyc  = c;
                got_bin = 64'(bus.peak_bin);
                got_mag = 64'(bus.peak_mag);
            end
            if (c < 258 && bus.peak_bin !== 9'(prev_bin)) held_ok = 0;
            step();
        end
        bus.fft_done = 1'b0;
        chk({tag, " adr_sweep_ok"}, 64'(adr_ok), 64'd1);
        chk({tag, " busy_window_ok"}, 64'(busy_ok), 64'd1);
        chk({tag, " held_prev_bin_ok"}, 64'(held_ok), 64'd1);
        chk({tag, " peak_valid_count"}, 64'(pv_cnt), 64'd1);
        chk({tag, " peak_valid_cycle"}, 64'(pv_cyc), 64'd258);
        chk({tag, " peak_bin"}, got_bin, 64'(exp_bin));
        chk({tag, " peak_mag"}, got_mag, exp_mag);
        chk({tag, " peak_bin_held_after"}, 64'(bus.peak_bin), 64'(exp_bin));
    endtask

    initial begin
        bit pv_seen;
        reset = 1'b0;
        bus.fft_done = 1'b0;
        fill(0, 0);
        repeat (3) step();
        chk("reset rd_adr", 64'(bus.rd_adr), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset peak_valid", 64'(bus.peak_valid), 64'd0);
        chk("reset peak_bin", 64'(bus.peak_bin), 64'd0);
        chk("reset peak_mag", 64'(bus.peak_mag), 64'd0);
        reset = 1'b1;
        repeat (2) step();

        // single tone: 1000^2 + 500^2
        fill(3, 4);
        mem[37] = word(1000, -500);
        run_scan("tone37", 37, 64'd1250000, 0, 0);

        // all-zero spectrum: bin stays at min_bin
        fill(0, 0);
        run_scan("zero", 1, 64'd0, 37, 0);

        // DC excluded, tie keeps the lower bin
        fill(0, 0);
        mem[0]   = word(32767, 0);
        mem[20]  = word(0, 300);
        mem[100] = word(0, 300);
        run_scan("dc_tie", 20, 64'd90000, 1, 0);

        // extreme: 2 * 2^30 beats 32767^2
        fill(32767, 0);
        mem[255] = word(-32768, -32768);
        run_scan("extreme", 255, 64'd2147483648, 20, 0);

        // ignored fft_done mid-scan and result held during next scan
        fill(3, 4);
        mem[37] = word(1000, -500);
        run_scan("tone37b", 37, 64'd1250000, 255, 0);
        fill(3, 4);
        mem[60] = word(-700, 200);
        run_scan("ignored_start", 60, 64'd530000, 37, 100);

        // reset at cycle 50 of a scan
        bus.fft_done = 1'b1;
        step();
        bus.fft_done = 1'b0;
        repeat (49) step();
        reset = 1'b0;
        #1;
        chk("midreset rd_adr", 64'(bus.rd_adr), 64'd0);
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset peak_valid", 64'(bus.peak_valid), 64'd0);
        chk("midreset peak_bin", 64'(bus.peak_bin), 64'd0);
        chk("midreset peak_mag", 64'(bus.peak_mag), 64'd0);
        pv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.peak_valid === 1'b1) pv_seen = 1;
        end
        reset = 1'b1;
        for (int i = 0; i < 260; i++) begin
            step();
            if (bus.peak_valid === 1'b1) pv_seen = 1;
        end
        chk("midreset no_peak_valid", 64'(pv_seen), 64'd0);
        chk("midreset idle_busy", 64'(bus.busy), 64'd0);
        run_scan("after_reset", 60, 64'd530000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
